// File: rtl/rx_engine.sv
// rx_engine: UART receive engine. Oversamples the serial line with a
// run-time bit-time divisor and reassembles 7/8-bit characters with an
// optional parity bit and one checked stop bit. The finished character and
// its status flags are held for the processor-side register interface.
module rx_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [18:0] baud_count,
  input  logic        eight,
  input  logic        p_en,
  input  logic        ohel,
  input  logic        read,
  output logic [7:0]  data,
  output logic        rxrdy,
  output logic        perr,
  output logic        ferr,
  output logic        ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RECV  = 2'd2;

  logic        rx_m;
  logic        rx_s;
  logic [1:0]  state;
  logic [18:0] cnt;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic        frame_done;

  logic [3:0]  frame_len;
  logic        expire;
  logic [9:0]  aligned;
  logic [7:0]  rx_data;
  logic        rx_par;
  logic        rx_stop;
  logic        par_err;

  // Frame geometry and decode of the completed shift register.
  // NOTE: every always_comb output gets a value on every path (here all are
  // plain assignments) so no latch can be inferred.
  always_comb begin
    frame_len = 4'd8 + {3'b000, eight} + {3'b000, p_en};
    expire    = (cnt == 19'd1);
    // Samples enter at the MSB, so after N samples the first data bit sits
    // at bit 10-N; shift it down to bit 0.
    aligned   = shreg >> (4'd10 - frame_len);
    rx_data   = {eight & aligned[7], aligned[6:0]};
    // Stop bit is always the last sample (MSB); parity precedes it.
    rx_stop   = shreg[9];
    rx_par    = shreg[8];
    par_err   = p_en & (rx_par != ((^rx_data) ^ ohel));
  end

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM: start detection, mid-bit sampling and frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            // Half a bit time puts the start sample at mid-bit.
            cnt   <= baud_count >> 1;
            state <= START;
          end
        end
        START: begin
          if (expire) begin
            if (rx_s) begin
              // Glitch shorter than half a bit: not a real start bit.
              state <= IDLE;
            end else begin
              cnt     <= baud_count;
              bit_cnt <= '0;
              state   <= RECV;
            end
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        RECV: begin
          if (expire) begin
            shreg   <= {rx_s, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            cnt     <= baud_count;
            if (bit_cnt == frame_len - 4'd1) begin
              // Stop bit just sampled; re-arm immediately for back-to-back.
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register and status flags; a completing frame beats a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 8'h00;
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end else if (frame_done) begin
      data  <= rx_data;
      perr  <= par_err;
      ferr  <= ~rx_stop;
      ovf   <= read ? 1'b0 : (ovf | rxrdy);
      rxrdy <= 1'b1;
    end else if (read) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_engine.sv
// tb_rx_engine: directed bench for rx_engine. Frames are driven bit by bit
// at 16 clocks per bit; the expected character and flags are pushed to a
// scoreboard when a frame is sent and popped when the result is checked.
module tb_rx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [18:0] baud_count;
  logic        eight;
  logic        p_en;
  logic        ohel;
  logic        read;
  logic [7:0]  data;
  logic        rxrdy;
  logic        perr;
  logic        ferr;
  logic        ovf;

  rx_engine dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_count (baud_count),
    .eight      (eight),
    .p_en       (p_en),
    .ohel       (ohel),
    .read       (read),
    .data       (data),
    .rxrdy      (rxrdy),
    .perr       (perr),
    .ferr       (ferr),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic m_rdy;
  logic m_ovf;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame under the current configuration. rd_at_done raises
  // read for the single cycle in which the frame completes; abort_bit >= 0
  // pulses rst mid-way through that bit and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit rd_at_done, input int abort_bit);
    int          n;
    logic [10:0] bits;
    logic [7:0]  dm;
    logic        odd_ones;
    exp_t        e;
    n    = 8 + int'(eight) + int'(p_en);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 7 + int'(eight); i++) bits[1 + i] = d[i];
    if (p_en) bits[n - 1] = par;
    bits[n] = stop;
    for (int b = 0; b <= n; b++) begin
      rx = bits[b];
      for (int c = 0; c < 16; c++) begin
        if (b == abort_bit && c == 8) begin
          rst = 1'b1;
          rx  = 1'b1;
          @(negedge clk);
          rst   = 1'b0;
          m_rdy = 1'b0;
          m_ovf = 1'b0;
          return;
        end
        read = (b == n && c == 11 && rd_at_done);
        @(negedge clk);
      end
    end
    read = 1'b0;
    rx   = 1'b1;
    dm       = eight ? d : {1'b0, d[6:0]};
    odd_ones = ($countones(dm) % 2) == 1;
    e.data   = dm;
    // Correct parity bit: even -> odd_ones, odd -> ~odd_ones.
    e.perr   = p_en && (par != (ohel ? ~odd_ones : odd_ones));
    e.ferr   = ~stop;
    e.ovf    = rd_at_done ? 1'b0 : (m_ovf | m_rdy);
    m_ovf    = e.ovf;
    m_rdy    = 1'b1;
    sb.push_back(e);
  endtask

  task automatic expect_frame(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected one frame", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".data"},  data,  e.data);
      chk({tag, ".rxrdy"}, {7'd0, rxrdy}, {7'd0, m_rdy});
      chk({tag, ".perr"},  {7'd0, perr},  {7'd0, e.perr});
      chk({tag, ".ferr"},  {7'd0, ferr},  {7'd0, e.ferr});
      chk({tag, ".ovf"},   {7'd0, ovf},   {7'd0, e.ovf});
    end
  endtask

  task automatic do_read(input string tag);
    read = 1'b1;
    @(negedge clk);
    read  = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    chk({tag, ".rxrdy_clr"}, {7'd0, rxrdy}, 8'd0);
    chk({tag, ".flags_clr"}, {5'd0, perr, ferr, ovf}, 8'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".data"},  data, 8'h00);
    chk({tag, ".flags"}, {4'd0, rxrdy, perr, ferr, ovf}, 8'd0);
    chk({tag, ".state"}, {6'd0, dut.state}, 8'd0);
  endtask

  initial begin
    rst        = 1'b1;
    rx         = 1'b1;
    read       = 1'b0;
    baud_count = 19'd16;
    eight      = 1'b1;
    p_en       = 1'b0;
    ohel       = 1'b0;
    m_rdy      = 1'b0;
    m_ovf      = 1'b0;
    idle(3);
    check_cleared("reset");
    rst = 1'b0;
    idle(5);

    // 8N1 baseline
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("8n1_a5");
    do_read("8n1_a5");
    idle(10);

    // 7-bit odd parity; bit 7 of the source byte must not reach data
    eight = 1'b0; p_en = 1'b1; ohel = 1'b1;
    send_frame(8'hC1, 1'b1, 1'b1, 1'b0, -1);
    expect_frame("7o1_good");
    do_read("7o1_good");
    idle(10);
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("7o1_bad");
    do_read("7o1_bad");
    idle(10);

    // 8E1 with the stop bit held low
    eight = 1'b1; p_en = 1'b1; ohel = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    expect_frame("8e1_ferr");
    idle(30);
    do_read("8e1_ferr");
    idle(10);

    // False start: 4-clock low glitch
    eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    chk("false_start.rxrdy", {7'd0, rxrdy}, 8'd0);
    chk("false_start.flags", {5'd0, perr, ferr, ovf}, 8'd0);
    chk("false_start.state", {6'd0, dut.state}, 8'd0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("after_false_55");
    do_read("after_false_55");
    idle(10);

    // Overrun, then read colliding with frame completion
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("ovr_11");
    idle(20);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("ovr_22");
    idle(20);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, -1);
    expect_frame("collide_33");
    idle(10);

    // Back-to-back frames with zero idle bits
    do_read("b2b_pre");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("b2b_5a");
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("b2b_c3");
    idle(10);

    // Reset during data bit 3 while a character is still held
    send_frame(8'h99, 1'b0, 1'b1, 1'b0, 4);
    check_cleared("mid_reset");
    idle(5);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("post_reset_f0");
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
